// File: rtl/std_mem_d1_copy.sv
// Copies len words from a source std_mem_d1 into a destination std_mem_d1, one word per write/done round trip.
// Go/done handshake: go is sampled only in IDLE and done pulses for exactly one cycle at the end of the copy.
module std_mem_d1_copy #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 16,
    parameter int IDX_SIZE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic [IDX_SIZE:0]   len,
    input  logic [IDX_SIZE-1:0] src_base,
    input  logic [IDX_SIZE-1:0] dst_base,
    output logic [IDX_SIZE-1:0] src_addr0,
    input  logic [WIDTH-1:0]    src_read_data,
    output logic [IDX_SIZE-1:0] dst_addr0,
    output logic [WIDTH-1:0]    dst_write_data,
    output logic                dst_write_en,
    input  logic                dst_done,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT, FINISH} state_t;

    state_t              state;
    logic [IDX_SIZE:0]   remaining;
    logic [IDX_SIZE-1:0] src_ptr;
    logic [IDX_SIZE-1:0] dst_ptr;
    logic                write_en_q;
    logic                done_q;
    logic                busy_q;

    // Wrap at SIZE-1; out-of-range bases fall through to natural modulo-2^IDX_SIZE wrap.
    function automatic logic [IDX_SIZE-1:0] next_ptr(input logic [IDX_SIZE-1:0] p);
        if (p == IDX_SIZE'(SIZE - 1))
            return '0;
        return p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            write_en_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        remaining <= len;
                        src_ptr   <= src_base;
                        dst_ptr   <= dst_base;
                        busy_q    <= 1'b1;
                        if (len == '0) begin
                            state  <= FINISH;
                            done_q <= 1'b1;
                        end else begin
                            state      <= WRITE;
                            write_en_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state      <= WAIT;
                    write_en_q <= 1'b0;
                end
                WAIT: begin
                    if (dst_done) begin
                        src_ptr   <= next_ptr(src_ptr);
                        dst_ptr   <= next_ptr(dst_ptr);
                        remaining <= remaining - 1'b1;
                        if (remaining == (IDX_SIZE + 1)'(1)) begin
                            state  <= FINISH;
                            done_q <= 1'b1;
                        end else begin
                            state      <= WRITE;
                            write_en_q <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    write_en_q <= 1'b0;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign src_addr0      = src_ptr;
    assign dst_addr0      = dst_ptr;
    assign dst_write_en   = write_en_q;
    // Source read data is combinational, so it passes straight through during the strobe.
    assign dst_write_data = write_en_q ? src_read_data : '0;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_std_mem_d1_copy.sv
// Bench for std_mem_d1_copy: behavioural source/destination memories, expected writes and done cycles queued by stimulus.
module tb_std_mem_d1_copy;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic [4:0]  len;
    logic [3:0]  src_base;
    logic [3:0]  dst_base;
    logic [3:0]  src_addr0;
    logic [31:0] src_read_data;
    logic [3:0]  dst_addr0;
    logic [31:0] dst_write_data;
    logic        dst_write_en;
    logic        dst_done;
    logic        busy;
    logic        done;

    std_mem_d1_copy #(.WIDTH(32), .SIZE(16), .IDX_SIZE(4)) dut (
        .clk(clk), .reset(reset), .go(go), .len(len),
        .src_base(src_base), .dst_base(dst_base),
        .src_addr0(src_addr0), .src_read_data(src_read_data),
        .dst_addr0(dst_addr0), .dst_write_data(dst_write_data),
        .dst_write_en(dst_write_en), .dst_done(dst_done),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] SRC_INIT [16] = '{
        32'h1000_00F0, 32'h1000_00F1, 32'hAAAA_0001, 32'hBBBB_0002,
        32'hCCCC_0003, 32'hDDDD_0004, 32'h6666_0006, 32'h7777_0007,
        32'h8888_0008, 32'h9999_0009, 32'h1010_000A, 32'h1111_000B,
        32'h1212_000C, 32'h1313_000D, 32'hEEEE_000E, 32'hFFFF_000F};

    typedef struct {
        logic [3:0]  sa;
        logic [3:0]  da;
        logic [31:0] d;
    } wr_t;

    wr_t   exp_wr[$];
    int    exp_done[$];
    wr_t   last_wr;
    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    t0 = 0;
    int    ddelay = 1;
    int    dcnt = 0;
    logic  clr = 1'b0;
    logic  prev_en = 1'b0;
    logic [31:0] src_mem [16];
    logic [31:0] dst_mem [16];

    assign src_read_data = src_mem[src_addr0];
    assign dst_done      = (dcnt == 1);

    always @(posedge clk) cyc <= cyc + 1;

    // Destination memory: writes land at the strobe edge, done returns ddelay cycles after the strobe.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) dst_mem[i] <= 32'hDEAD_0000 + 32'(i);
        end else if (dst_write_en) begin
            dst_mem[dst_addr0] <= dst_write_data;
        end
        if (dst_write_en) dcnt <= ddelay;
        else if (dcnt != 0) dcnt <= dcnt - 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        wr_t w;
        if (dst_write_en) begin
            chk("no_back_to_back_strobe", {31'd0, prev_en}, 32'd0);
            chk("busy_during_write", {31'd0, busy}, 32'd1);
            if (exp_wr.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write", dst_addr0, dst_write_data);
            end else begin
                w = exp_wr.pop_front();
                chk("src_addr", {28'd0, src_addr0}, {28'd0, w.sa});
                chk("dst_addr", {28'd0, dst_addr0}, {28'd0, w.da});
                chk("write_data", dst_write_data, w.d);
                last_wr <= w;
            end
        end else begin
            chk("wdata_zero_when_idle", dst_write_data, 32'd0);
        end
        if (done) begin
            chk("busy_during_done", {31'd0, busy}, 32'd1);
            if (exp_done.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                chk("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
            end
        end
        if (busy && !dst_write_en && !done) begin
            chk("src_addr_held_wait", {28'd0, src_addr0}, {28'd0, last_wr.sa});
            chk("dst_addr_held_wait", {28'd0, dst_addr0}, {28'd0, last_wr.da});
        end
        prev_en <= dst_write_en;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_copy(input int n, input int sb, input int db);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.sa = 4'((sb + i) % 16);
            w.da = 4'((db + i) % 16);
            w.d  = SRC_INIT[w.sa];
            exp_wr.push_back(w);
        end
    endtask

    // Raises go for the cycle following the call and queues the expected writes and done cycle.
    task automatic start(input int l, input int sb, input int db, input int extra);
        len      = 5'(l);
        src_base = 4'(sb);
        dst_base = 4'(db);
        go       = 1'b1;
        t0       = cyc;
        push_copy(l, sb, db);
        exp_done.push_back(t0 + 2 * l + 1 + l * extra);
        tick(1);
    endtask

    task automatic clear_dst();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    task automatic settle(input string nm);
        tick(30);
        chk({nm, "_writes_drained"}, 32'(exp_wr.size()), 32'd0);
        chk({nm, "_done_drained"}, 32'(exp_done.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) src_mem[i] = SRC_INIT[i];
        reset = 1'b1; go = 1'b0; len = '0; src_base = '0; dst_base = '0;
        clr = 1'b1;
        tick(3);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wen", {31'd0, dst_write_en}, 32'd0);
        chk("rst_wdata", dst_write_data, 32'd0);
        chk("rst_src_addr", {28'd0, src_addr0}, 32'd0);
        chk("rst_dst_addr", {28'd0, dst_addr0}, 32'd0);
        reset = 1'b0;
        clr = 1'b0;
        tick(2);

        // Copy with offsets: done at cycle 9, neighbours untouched.
        start(4, 2, 5, 0);
        go = 1'b0;
        settle("offset");
        chk("offset_dst4", dst_mem[4], 32'hDEAD_0004);
        chk("offset_dst5", dst_mem[5], 32'hAAAA_0001);
        chk("offset_dst6", dst_mem[6], 32'hBBBB_0002);
        chk("offset_dst7", dst_mem[7], 32'hCCCC_0003);
        chk("offset_dst8", dst_mem[8], 32'hDDDD_0004);
        chk("offset_dst9", dst_mem[9], 32'hDEAD_0009);

        // Zero length: busy only in cycle 1.
        clear_dst();
        len = '0; src_base = 4'd3; dst_base = 4'd3; go = 1'b1; t0 = cyc;
        exp_done.push_back(t0 + 1);
        chk("zero_busy_c0", {31'd0, busy}, 32'd0);
        tick(1);
        go = 1'b0;
        chk("zero_busy_c1", {31'd0, busy}, 32'd1);
        tick(1);
        chk("zero_busy_c2", {31'd0, busy}, 32'd0);
        settle("zero");
        chk("zero_dst3", dst_mem[3], 32'hDEAD_0003);

        // Wrap-around: src 14,15,0,1 -> dst 15,0,1,2.
        clear_dst();
        start(4, 14, 15, 0);
        go = 1'b0;
        settle("wrap");
        chk("wrap_dst15", dst_mem[15], 32'hEEEE_000E);
        chk("wrap_dst0", dst_mem[0], 32'hFFFF_000F);
        chk("wrap_dst1", dst_mem[1], 32'h1000_00F0);
        chk("wrap_dst2", dst_mem[2], 32'h1000_00F1);

        // Slow destination: done 3 cycles after each strobe, copy done at cycle 9.
        clear_dst();
        ddelay = 3;
        start(2, 6, 3, 2);
        go = 1'b0;
        settle("slow");
        ddelay = 1;
        chk("slow_dst3", dst_mem[3], 32'h6666_0006);
        chk("slow_dst4", dst_mem[4], 32'h7777_0007);

        // go toggled mid-copy must not restart or add a done.
        clear_dst();
        start(3, 8, 0, 0);
        go = 1'b0;
        tick(1);
        go = 1'b1;
        tick(2);
        go = 1'b0;
        settle("go_toggle");

        // go held through done: second copy with the then-current inputs starts at cycle 6.
        clear_dst();
        start(2, 0, 10, 0);
        len = 5'd1; src_base = 4'd3; dst_base = 4'd12;
        push_copy(1, 3, 12);
        exp_done.push_back(t0 + 6 + 3);
        tick(6);
        go = 1'b0;
        settle("go_held");
        chk("held_dst10", dst_mem[10], 32'h1000_00F0);
        chk("held_dst11", dst_mem[11], 32'h1000_00F1);
        chk("held_dst12", dst_mem[12], 32'hBBBB_0002);

        // Reset at cycle 5 (third strobe): three words land, no done ever.
        clear_dst();
        len = 5'd4; src_base = 4'd0; dst_base = 4'd0; go = 1'b1; t0 = cyc;
        push_copy(3, 0, 0);
        tick(1);
        go = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_wen", {31'd0, dst_write_en}, 32'd0);
        chk("mid_rst_wdata", dst_write_data, 32'd0);
        chk("mid_rst_src_addr", {28'd0, src_addr0}, 32'd0);
        chk("mid_rst_dst_addr", {28'd0, dst_addr0}, 32'd0);
        settle("mid_rst");
        chk("mid_rst_dst0", dst_mem[0], 32'h1000_00F0);
        chk("mid_rst_dst2", dst_mem[2], 32'hAAAA_0001);
        chk("mid_rst_dst3", dst_mem[3], 32'hDEAD_0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
